alu_req_scheduler: RTL

//  Shares one 4-bit combinational ALU between NREQ requesters via round-robin arbitration.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu.sv | 47 ++++
 rtl/alu_req_scheduler_rr_arbiter.sv | 34 +++
 rtl/alu_req_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: widths, FSM states and ALU op selects.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam logic [3:0] OP_INC_A  = 4'h0;
  localparam logic [3:0] OP_DEC_A  = 4'h1;
  localparam logic [3:0] OP_PASS_B = 4'h2;
  localparam logic [3:0] OP_INC_B  = 4'h3;
  localparam logic [3:0] OP_DEC_B  = 4'h4;
  localparam logic [3:0] OP_PASS_A = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SHL_A  = 4'h7;
  localparam logic [3:0] OP_NOT_A  = 4'h8;
  localparam logic [3:0] OP_NOT_B  = 4'h9;
  localparam logic [3:0] OP_AND    = 4'hA;
  localparam logic [3:0] OP_OR     = 4'hB;
  localparam logic [3:0] OP_XOR    = 4'hC;
  localparam logic [3:0] OP_XNOR   = 4'hD;
  localparam logic [3:0] OP_NAND   = 4'hE;
  localparam logic [3:0] OP_NOR    = 4'hF;

endpackage

// File: rtl/alu.sv
// 4-bit combinational ALU: arithmetic ops give a zero-extended 4-bit result,
// logic ops work on sign-extended 5-bit operands.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       sel,
  output logic [RES_W-1:0] y
);

  logic [ALU_W-1:0] arith;
  logic [RES_W-1:0] ax;
  logic [RES_W-1:0] bx;

  assign ax = {a[ALU_W-1], a};
  assign bx = {b[ALU_W-1], b};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    arith = '0;
    y     = '0;
    case (sel)
      OP_INC_A:  arith = a + 4'd1;
      OP_DEC_A:  arith = a - 4'd1;
      OP_PASS_B: arith = b;
      OP_INC_B:  arith = b + 4'd1;
      OP_DEC_B:  arith = b - 4'd1;
      OP_PASS_A: arith = a;
      OP_ADD:    arith = a + b;
      OP_SHL_A:  arith = {a[ALU_W-2:0], 1'b0};
      default:   arith = '0;
    endcase
    case (sel)
      OP_NOT_A: y = ~ax;
      OP_NOT_B: y = ~bx;
      OP_AND:   y = ax & bx;
      OP_OR:    y = ax | bx;
      OP_XOR:   y = ax ^ bx;
      OP_XNOR:  y = ~(ax ^ bx);
      OP_NAND:  y = ~(ax & bx);
      OP_NOR:   y = ~(ax | bx);
      default:  y = {1'b0, arith};
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the lowest valid index at or after rr_ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_any && req_valid[j] && (IDW'(j) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
    // Nothing at or above the pointer: wrap around and search from index 0.
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU among NREQ requesters (IDLE -> EXEC -> RESP), one op in flight.
// Define ALU_SCHED_STATS_EN to add the saturating op_count output.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  input  logic [ALU_W*NREQ-1:0] req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_W-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [7:0]            op_count
`endif
);

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ALU_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_y_q, rsp_y_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [7:0]       op_count_q, op_count_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [RES_W-1:0] alu_y;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  alu u_alu (
    .a   (op_a_q),
    .b   (op_b_q),
    .sel (op_sel_q),
    .y   (alu_y)
  );

  // Gated by rst so no handshake can complete while reset is held.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_a_d   = req_a[int'(grant_idx)*ALU_W +: ALU_W];
          op_b_d   = req_b[int'(grant_idx)*ALU_W +: ALU_W];
          op_sel_d = req_sel[int'(grant_idx)*ALU_W +: ALU_W];
          op_id_d  = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = alu_y;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (op_count_q != 8'hFF) op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end

`ifdef ALU_SCHED_STATS_EN
  assign op_count = op_count_q;
`else
  logic unused_stats;
  assign unused_stats = ^op_count_d;
`endif

endmodule
